parity_frame_tx: RTL and testbench
==================================

// Module: parity_frame_tx
//
// PURPOSE
//   Upstream stage of the parity checker. Accepts a DATA_W-bit word through a
//   valid/ready handshake and computes its parity bit. Sends the word on a
//   single serial line as a frame: start(0), data LSB-first, parity, stop(1).
//   The frame drives the checker/receiver stage and the bench's serial monitor.
//
// PARAMETERS
//   DATA_W      4   payload width in bits (>=1)
//   PARITY_ODD  0   0: even parity bit = ^data; 1: odd parity bit = ~^data
//   BIT_CYCLES  1   clock cycles each frame bit is held on tx (>=1)
//
// PORTS
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous reset, active-high
//   in_data    in   DATA_W  word to send; sampled only on handshake
//   in_valid   in   1       in_data is valid
//   in_ready   out  1       block can accept a word (high only in IDLE)
//   tx         out  1       serial output, idle-high
//   busy       out  1       high while a frame is being sent (not IDLE)
//   frame_done out  1       1-cycle pulse during last cycle of STOP bit
//
// BEHAVIOUR
//   - Reset (async, immediate): state=IDLE, tx=1, in_ready=1, busy=0,
//     frame_done=0, counters=0, data/parity regs=0. All outputs registered.
//   - Handshake: a word is accepted on a rising edge where in_valid&&in_ready.
//     That edge latches in_data, latches the parity bit (^in_data ^ PARITY_ODD),
//     moves state to START, and sets tx=0, in_ready=0, busy=1. Latency:
//     tx goes low in the cycle right after the handshake cycle.
//   - FSM: IDLE -> START -> DATA -> PARITY -> STOP -> IDLE.
//     Each of START, PARITY and STOP lasts BIT_CYCLES cycles.
//     DATA lasts DATA_W*BIT_CYCLES cycles. Bit i is driven on tx in slot i,
//     LSB first. Bit index counter is $clog2(DATA_W) bits wide, or 1 bit if
//     DATA_W=1. Cycle counter counts 0..BIT_CYCLES-1 and wraps to 0 at every
//     bit boundary.
//   - tx value per state: START=0, DATA=data[idx], PARITY=parity, STOP=1,
//     IDLE=1.
//   - Frame length = (DATA_W+3)*BIT_CYCLES cycles from first tx=0 to end of
//     STOP.
//   - frame_done=1 only in the final cycle of STOP. The next edge returns the
//     state to IDLE and sets in_ready=1 and busy=0.
//   - Back-to-back: if in_valid is held high, the next handshake occurs one
//     cycle after in_ready rises. So exactly one IDLE cycle (tx=1) separates
//     frames.
//   - in_data and in_valid are ignored while busy. The latched word cannot
//     change mid-frame.
//   - in_valid low in IDLE: block stays IDLE and tx stays 1 indefinitely.
//   - rst asserted mid-frame: frame is abandoned at once, tx=1, no frame_done
//     pulse. After release the block is in IDLE with in_ready=1.
//
// TESTING
//   1. Reset with rst=1 for 1 cycle -> tx=1, in_ready=1, busy=0,
//      frame_done=0 throughout reset and after.
//   2. DATA_W=4, PARITY_ODD=0, BIT_CYCLES=1, send 4'b0100 -> tx = 0,0,0,1,0,
//      1,1 (start, d0..d3, parity=1, stop). frame_done in 7th cycle.
//   3. Send 4'b0110 then 4'b1111 with in_valid held high -> parity bits 0 and
//      0. in_ready low 7 cycles per frame. Exactly one tx=1 idle cycle between
//      frames.
//   4. PARITY_ODD=1, send 4'b1111 -> parity bit=1. Send 4'b0111 -> parity
//      bit=0.
//   5. BIT_CYCLES=2, send 4'b0101 -> each bit held 2 cycles.
//      Frame = 14 cycles. frame_done in cycle 14 only.
//   6. Assert rst during the DATA state of 4'b1010 -> tx=1 immediately, no
//      frame_done. Next word 4'b0001 sends a clean frame 0,1,0,0,0,1,1.

Source files
------------

// File: rtl/parity_frame_tx.sv
// Serialises one DATA_W-bit word per valid/ready handshake as start(0), data LSB-first,
// parity, stop(1); every bit held BIT_CYCLES clocks, all outputs registered.
module parity_frame_tx #(
  parameter int DATA_W     = 4,
  parameter int PARITY_ODD = 0,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
  localparam logic ODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     idx, idx_n;
  logic [DATA_W-1:0] data, data_n;
  logic              par, par_n;
  logic              tx_n, frame_done_n, bit_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      data       <= '0;
      par        <= 1'b0;
      tx         <= 1'b1;
      in_ready   <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      data       <= data_n;
      par        <= par_n;
      tx         <= tx_n;
      in_ready   <= (state_n == IDLE);
      busy       <= (state_n != IDLE);
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    data_n  = data;
    par_n   = par;
    bit_end = (cnt == CNT_LAST);

    // Cycle counter wraps at every bit boundary; it rests at 0 while idle.
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + CW'(1);

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          data_n  = in_data;
          par_n   = (^in_data) ^ ODD;
          state_n = START;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      START:  if (bit_end) state_n = DATA;
      DATA: begin
        if (bit_end) begin
          if (idx == IDX_LAST) begin
            state_n = PARITY;
            idx_n   = '0;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      PARITY: if (bit_end) state_n = STOP;
      STOP:   if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the next-state values.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = data_n[idx_n];
      PARITY:  tx_n = par_n;
      default: tx_n = 1'b1;
    endcase
    frame_done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx: three instances (even/1, odd/1, even/2 cycles per bit)
// compared cycle by cycle against frames built from the framing rules.
module tb_parity_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data  [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       tx       [3];
  logic       busy     [3];
  logic       frame_done [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(4), .PARITY_ODD(0), .BIT_CYCLES(1)) u_even (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .tx(tx[0]), .busy(busy[0]), .frame_done(frame_done[0]));

  parity_frame_tx #(.DATA_W(4), .PARITY_ODD(1), .BIT_CYCLES(1)) u_odd (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .tx(tx[1]), .busy(busy[1]), .frame_done(frame_done[1]));

  parity_frame_tx #(.DATA_W(4), .PARITY_ODD(0), .BIT_CYCLES(2)) u_slow (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .tx(tx[2]), .busy(busy[2]), .frame_done(frame_done[2]));

  function automatic int odd_of(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int bc_of(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: expand the word into the per-cycle line levels of one frame.
  task automatic send_frame(input int k, input logic [3:0] w, input bit keep);
    bit q[$];
    int b;
    bit p;
    b = bc_of(k);
    p = ((w[0] + w[1] + w[2] + w[3]) % 2 == 1) ^ (odd_of(k) != 0);
    q = {};
    for (int j = 0; j < b; j++) q.push_back(1'b0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < b; j++) q.push_back(w[i]);
    for (int j = 0; j < b; j++) q.push_back(p);
    for (int j = 0; j < b; j++) q.push_back(1'b1);

    chk($sformatf("u%0d pre_ready", k), 32'(in_ready[k]), 32'd1);
    in_data[k]  = w;
    in_valid[k] = 1'b1;
    tick();
    for (int c = 0; c < q.size(); c++) begin
      in_data[k]  = 4'($urandom);
      in_valid[k] = 1'($urandom);
      chk($sformatf("u%0d w=%h tx[%0d]", k, w, c), 32'(tx[k]), 32'(q[c]));
      chk($sformatf("u%0d busy[%0d]", k, c), 32'(busy[k]), 32'd1);
      chk($sformatf("u%0d ready[%0d]", k, c), 32'(in_ready[k]), 32'd0);
      chk($sformatf("u%0d done[%0d]", k, c), 32'(frame_done[k]), 32'(c == q.size() - 1));
      tick();
    end
    chk($sformatf("u%0d idle_tx", k), 32'(tx[k]), 32'd1);
    chk($sformatf("u%0d idle_ready", k), 32'(in_ready[k]), 32'd1);
    chk($sformatf("u%0d idle_busy", k), 32'(busy[k]), 32'd0);
    chk($sformatf("u%0d idle_done", k), 32'(frame_done[k]), 32'd0);
    in_valid[k] = keep;
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s u%0d tx", tag, k), 32'(tx[k]), 32'd1);
      chk($sformatf("%s u%0d ready", tag, k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("%s u%0d busy", tag, k), 32'(busy[k]), 32'd0);
      chk($sformatf("%s u%0d done", tag, k), 32'(frame_done[k]), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data[k]  = 4'h0;
      in_valid[k] = 1'b0;
    end
    #2;
    check_idle("in_reset");
    tick();
    check_idle("in_reset_edge");
    rst = 1'b0;
    tick();
    check_idle("after_reset");

    // Directed frames
    send_frame(0, 4'b0100, 1'b0);
    send_frame(0, 4'b0110, 1'b1);
    send_frame(0, 4'b1111, 1'b0);
    send_frame(1, 4'b1111, 1'b0);
    send_frame(1, 4'b0111, 1'b0);
    send_frame(2, 4'b0101, 1'b0);

    // Idle line with no valid stays high
    for (int i = 0; i < 5; i++) begin
      tick();
      check_idle("long_idle");
    end

    // Reset in the middle of the first data bit of 4'b1010
    chk("u0 rst_pre_ready", 32'(in_ready[0]), 32'd1);
    in_data[0]  = 4'b1010;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    chk("u0 rst_start_tx", 32'(tx[0]), 32'd0);
    tick();
    chk("u0 rst_d0_tx", 32'(tx[0]), 32'd0);
    chk("u0 rst_d0_busy", 32'(busy[0]), 32'd1);
    rst = 1'b1;
    #1;
    check_idle("mid_rst");
    tick();
    check_idle("mid_rst_hold");
    rst = 1'b0;
    tick();
    check_idle("mid_rst_after");
    send_frame(0, 4'b0001, 1'b0);

    // Random words, randomly back-to-back
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 10; n++) begin
        send_frame(k, 4'($urandom), (n < 9) ? 1'($urandom) : 1'b0);
      end
      tick();
      chk($sformatf("u%0d rand_end_ready", k), 32'(in_ready[k]), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
